// File: rtl/sipo_stream.sv
// sipo_stream: serial-in, parallel-out stream deserialiser.
//
// Gathers en-qualified serial bits from sin into DATA_W-bit words, in
// LSB-first or MSB-first order. The order is chosen per word by msb_first,
// sampled on the first bit of the word. Completed words go into a
// DEPTH-entry FIFO that drains over a valid/ready stream. A word that
// completes while the FIFO is full, with no pop on the same edge, is
// dropped and raises the sticky ovf flag. Serial input is never stalled.
//
// Ports:
//   clk, rstn         clock; asynchronous active-low reset
//   en, sin           serial bit strobe and data
//   msb_first         bit order for the next word
//   flush             synchronous clear of the FIFO and any partial word
//   clr_ovf           clears ovf (a drop on the same edge wins)
//   m_valid, m_ready  output stream handshake
//   m_data            head-of-FIFO word
//   level             FIFO occupancy, 0..DEPTH
//   ovf               sticky word-dropped flag
//   m_perr            (parity build only) parity error flag of head word
//
// Build option: define SIPO_STREAM_PARITY_EN to enable parity mode. Each
// frame then carries one trailing even-parity bit. Every FIFO entry stores
// a perr flag, which is presented on m_perr.
module sipo_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     sin,
    input  logic                     msb_first,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   level,
`ifdef SIPO_STREAM_PARITY_EN
    output logic                     m_perr,
`endif
    output logic                     ovf
);

`ifdef SIPO_STREAM_PARITY_EN
    localparam int EW     = DATA_W + 1;  // data + perr flag
    localparam int LAST_I = DATA_W;      // last frame bit is parity
`else
    localparam int EW     = DATA_W;
    localparam int LAST_I = DATA_W - 1;
`endif
    localparam int CW = $clog2(LAST_I + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0]                cnt_q, cnt_d;
    logic [DATA_W-1:0]            sreg_q, sreg_d;
    logic                         mode_q, mode_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic                         ovf_q, ovf_d;
    logic [DEPTH-1:0][EW-1:0]     mem_q;
`ifdef SIPO_STREAM_PARITY_EN
    logic                         par_q, par_d;
`endif

    logic                         mode_c;
    logic                         last_c;
    logic                         data_bit_c;
    logic [DATA_W-1:0]            sreg_nxt;
    logic [EW-1:0]                word_c;
    logic                         empty_c, full_c;
    logic                         pop_c, push_c, we_c;

    // The mode is taken live from msb_first on the first bit. It is held in
    // mode_q for the rest of the word.
    assign mode_c = (cnt_q == '0) ? msb_first : mode_q;
    assign last_c = (cnt_q == LAST);

`ifdef SIPO_STREAM_PARITY_EN
    assign data_bit_c = !last_c;
    // Even parity over the data and parity bits: an odd ones count is an error.
    assign word_c     = {par_q ^ sin, sreg_q};
`else
    assign data_bit_c = 1'b1;
    // The completed word includes the bit arriving on this edge.
    assign word_c     = sreg_nxt;
`endif

    always_comb begin
        sreg_nxt = sreg_q;
        if (data_bit_c) begin
            if (mode_c) begin
                sreg_nxt = {sreg_q[DATA_W-2:0], sin};
            end else begin
                for (int k = 0; k < DATA_W; k++) begin
                    if (cnt_q == CW'(k)) sreg_nxt[k] = sin;
                end
            end
        end
    end

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        mode_d   = mode_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = clr_ovf ? 1'b0 : ovf_q;
        we_c     = 1'b0;
        pop_c    = 1'b0;
        push_c   = 1'b0;
`ifdef SIPO_STREAM_PARITY_EN
        par_d    = par_q;
`endif
        if (flush) begin
            // flush overrides everything except ovf; the bit on this edge is lost
            cnt_d    = '0;
            sreg_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
`ifdef SIPO_STREAM_PARITY_EN
            par_d    = 1'b0;
`endif
        end else begin
            pop_c  = !empty_c && m_ready;
            push_c = en && last_c;
            if (en) begin
                cnt_d  = last_c ? '0 : cnt_q + 1'b1;
                sreg_d = sreg_nxt;
                mode_d = mode_c;
`ifdef SIPO_STREAM_PARITY_EN
                par_d  = (cnt_q == '0) ? sin : (par_q ^ sin);
`endif
            end
            if (pop_c) rd_ptr_d = rd_ptr_q + 1'b1;
            // On a full FIFO a same-edge pop frees the slot being written.
            if (push_c) begin
                if (!full_c || pop_c) begin
                    we_c     = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            sreg_q   <= '0;
            mode_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            mem_q    <= '0;
`ifdef SIPO_STREAM_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            if (we_c) mem_q[wr_ptr_q[AW-1:0]] <= word_c;
`ifdef SIPO_STREAM_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign m_valid = !empty_c;
    assign level   = wr_ptr_q - rd_ptr_q;
    assign m_data  = mem_q[rd_ptr_q[AW-1:0]][DATA_W-1:0];
    assign ovf     = ovf_q;
`ifdef SIPO_STREAM_PARITY_EN
    assign m_perr  = mem_q[rd_ptr_q[AW-1:0]][DATA_W];
`endif

endmodule

// File: tb/tb_sipo_stream.sv
// Directed self-checking bench for sipo_stream (DATA_W=8, DEPTH=4).
module tb_sipo_stream;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       sin = 1'b0;
    logic       msb_first = 1'b0;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       m_ready = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic [2:0] level;
    logic       ovf;
`ifdef SIPO_STREAM_PARITY_EN
    logic       m_perr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    sipo_stream #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .sin(sin), .msb_first(msb_first),
        .flush(flush), .clr_ovf(clr_ovf), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .level(level),
`ifdef SIPO_STREAM_PARITY_EN
        .m_perr(m_perr),
`endif
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs are driven and outputs sampled 1 time unit after
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic msb);
        en = 1'b1; sin = b; msb_first = msb;
        tick();
        en = 1'b0;
    endtask

    // Send word w in frame order for the chosen bit order. m_ready and
    // clr_ovf can be asserted on the last bit edge only.
    task automatic send_word(input logic [7:0] w, input logic msb,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            en = 1'b1;
            msb_first = msb;
            sin = msb ? w[7-i] : w[i];
            if (i == 7) begin
                m_ready = rdy_last;
                clr_ovf = clr_last;
            end
            tick();
        end
        en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    logic [7:0] frame;

    initial begin
        // reset state
        #12;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rstn = 1'b1;
        tick();

        // LSB-first: bits 1,0,1,0,0,0,0,1 -> 0x85
        frame = 8'b1000_0101;  // frame[i] is the i-th bit sent
        for (int i = 0; i < 8; i++) send_bit(frame[i], 1'b0);
        chk("lsb_valid", 32'(m_valid), 1);
        chk("lsb_data", 32'(m_data), 32'h85);
        chk("lsb_level", 32'(level), 1);
        pop_one();
        chk("lsb_pop_valid", 32'(m_valid), 0);
        chk("lsb_pop_level", 32'(level), 0);

        // MSB-first, msb_first dropped after the first bit -> 0xA1
        for (int i = 0; i < 8; i++) send_bit(frame[i], (i == 0));
        chk("msb_valid", 32'(m_valid), 1);
        chk("msb_data", 32'(m_data), 32'hA1);
        pop_one();

        // overflow: five words, no consumer
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0, 1'b0);
        send_word(8'h44, 1'b0, 1'b0, 1'b0);
        chk("full_level", 32'(level), 4);
        chk("full_ovf", 32'(ovf), 0);
        send_word(8'h55, 1'b0, 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_pop0", 32'(m_data), 32'h11); pop_one();
        chk("ovf_pop1", 32'(m_data), 32'h22); pop_one();
        chk("ovf_pop2", 32'(m_data), 32'h33); pop_one();
        chk("ovf_pop3", 32'(m_data), 32'h44); pop_one();
        chk("ovf_drained", 32'(m_valid), 0);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);

        // full FIFO with a pop on the same edge as the push
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0, 1'b0);
        send_word(8'h44, 1'b0, 1'b0, 1'b0);
        send_word(8'h66, 1'b0, 1'b1, 1'b0);
        chk("fp_level", 32'(level), 4);
        chk("fp_ovf", 32'(ovf), 0);
        chk("fp_head", 32'(m_data), 32'h22); pop_one();
        chk("fp_pop1", 32'(m_data), 32'h33); pop_one();
        chk("fp_pop2", 32'(m_data), 32'h44); pop_one();
        chk("fp_last", 32'(m_data), 32'h66); pop_one();
        chk("fp_empty", 32'(m_valid), 0);

        // flush with two words queued and three bits of a partial word
        send_word(8'h01, 1'b0, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk("pre_flush_level", 32'(level), 2);
        flush = 1'b1; en = 1'b1; sin = 1'b1; m_ready = 1'b1;
        tick();
        flush = 1'b0; en = 1'b0; m_ready = 1'b0;
        chk("flush_level", 32'(level), 0);
        chk("flush_valid", 32'(m_valid), 0);
        send_word(8'hF0, 1'b0, 1'b0, 1'b0);
        chk("flush_data", 32'(m_data), 32'hF0);
        chk("flush_level1", 32'(level), 1);

        // a drop on the same edge as clr_ovf keeps ovf set
        send_word(8'hA0, 1'b1, 1'b0, 1'b0);
        send_word(8'hA1, 1'b1, 1'b0, 1'b0);
        send_word(8'hA2, 1'b1, 1'b0, 1'b0);
        send_word(8'hA3, 1'b1, 1'b0, 1'b1);
        chk("drop_clr_ovf", 32'(ovf), 1);
        chk("drop_clr_level", 32'(level), 4);
        chk("drop_clr_head", 32'(m_data), 32'hF0);

        // asynchronous reset mid-word, away from a clock edge
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(m_valid), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_ovf", 32'(ovf), 0);
        tick();
        rstn = 1'b1;
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("arst_word", 32'(m_data), 32'h3C);
        chk("arst_level1", 32'(level), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
